// File: rtl/doa_tracker.sv
// Direction-of-arrival tracker: periodically starts the mic-array sub-system, clamps and averages
// the returned lag, and maps it to an overlay pixel column. Optional feature macro: DOA_AVG_EN.
module doa_tracker #(
    parameter int LAGNUM   = 16,
    parameter int AVG_LOG2 = 2,
    parameter int SCREEN_W = 640,
    parameter int PERIOD   = 600000,
    parameter int TIMEOUT  = 6000000
) (
    input  logic              clk_60MHz,
    input  logic              rst_n,
    input  logic              enable,
    output logic              subsys_start,
    input  logic              subsys_done,
    input  logic signed [5:0] lag_diff,
    output logic [10:0]       pos_x,
    output logic              pos_valid,
    output logic              timeout_err
);
    localparam int SHIFT = $clog2(2 * LAGNUM);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_DONE, S_FILTER, S_MAP, S_WAIT_PERIOD
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        per_q, per_d, wd_q, wd_d;
    logic signed [5:0]  lag_q;
    logic [10:0]        pos_x_q;
    logic               pos_valid_q, tmo_q;
    logic signed [5:0]  avg;
    logic               filled;
    logic signed [31:0] off;
    logic [31:0]        prod;
    logic [10:0]        map_x;

    function automatic logic signed [5:0] clamp(input logic signed [5:0] v);
        if (int'(v) > LAGNUM)  return 6'(LAGNUM);
        if (int'(v) < -LAGNUM) return 6'(-LAGNUM);
        return v;
    endfunction

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            per_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:        if (enable) state_d = S_START;
            S_START:       state_d = enable ? S_WAIT_DONE : S_IDLE;
            S_WAIT_DONE: begin
                // done wins over a same-cycle watchdog expiry
                if (subsys_done)    state_d = S_FILTER;
                else if (wd_q == 0) state_d = enable ? S_WAIT_PERIOD : S_IDLE;
            end
            S_FILTER:      state_d = S_MAP;
            S_MAP:         state_d = !enable ? S_IDLE : (per_q == 0) ? S_START : S_WAIT_PERIOD;
            S_WAIT_PERIOD: if (!enable) state_d = S_IDLE;
                           else if (per_q == 0) state_d = S_START;
            default:       state_d = S_IDLE;
        endcase
    end

    // Counters load on entry to START so the START cycle already holds PERIOD-1 / TIMEOUT-1;
    // this makes start-to-start spacing exactly PERIOD.
    always_comb begin
        per_d = per_q;
        wd_d  = wd_q;
        if (state_d == S_START && state_q != S_START) begin
            per_d = 32'(PERIOD - 1);
            wd_d  = 32'(TIMEOUT - 1);
        end else begin
            if (per_q != 0) per_d = per_q - 32'd1;
            if (wd_q != 0)  wd_d  = wd_q - 32'd1;
        end
    end

    always_comb begin
        subsys_start = (state_q == S_START);
        pos_x        = pos_x_q;
        pos_valid    = pos_valid_q;
        timeout_err  = tmo_q;
    end

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            lag_q       <= '0;
            pos_x_q     <= '0;
            pos_valid_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            pos_valid_q <= 1'b0;
            if (state_q == S_IDLE) tmo_q <= 1'b0;
            if (state_q == S_WAIT_DONE) begin
                if (subsys_done)    lag_q <= clamp(lag_diff);
                else if (wd_q == 0) tmo_q <= 1'b1;
            end
            if (state_q == S_MAP) begin
                pos_x_q     <= map_x;
                pos_valid_q <= filled;
            end
        end
    end

`ifdef DOA_AVG_EN
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 6 + AVG_LOG2;

    logic [DEPTH-1:0][5:0]  ring_q;
    logic signed [SW-1:0]   sum_q;
    logic [AVG_LOG2-1:0]    wr_q;
    logic [AVG_LOG2:0]      fill_q;

    always_ff @(posedge clk_60MHz or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= '0;
            sum_q  <= '0;
            wr_q   <= '0;
            fill_q <= '0;
        end else if (state_q == S_IDLE) begin
            ring_q <= '0;
            sum_q  <= '0;
            wr_q   <= '0;
            fill_q <= '0;
        end else if (state_q == S_FILTER) begin
            // evicted slot is zero until the ring has wrapped once
            ring_q[wr_q] <= lag_q;
            sum_q        <= sum_q + SW'(lag_q) - SW'($signed(ring_q[wr_q]));
            wr_q         <= wr_q + 1'b1;
            if (fill_q != (AVG_LOG2 + 1)'(DEPTH)) fill_q <= fill_q + 1'b1;
        end
    end

    always_comb begin
        avg    = 6'(sum_q >>> AVG_LOG2);
        filled = (fill_q == (AVG_LOG2 + 1)'(DEPTH));
    end
`else
    always_comb begin
        avg    = lag_q;
        filled = 1'b1;
    end
`endif

    always_comb begin
        off   = 32'(avg) + 32'(LAGNUM);
        prod  = off * (SCREEN_W - 1);
        map_x = 11'(prod >> SHIFT);
    end
endmodule

// File: tb/tb_doa_tracker.sv
// Self-checking bench for doa_tracker (PERIOD=100, TIMEOUT=50); expectations follow DOA_AVG_EN.
module tb_doa_tracker;
    logic              clk = 1'b0;
    logic              rst_n, enable, subsys_done;
    logic signed [5:0] lag_diff;
    logic              subsys_start, pos_valid, timeout_err;
    logic [10:0]       pos_x;

    typedef struct { int lag; int pos; int vld; } vec_t;
    typedef struct { int due; int pos; int vld; } sb_t;

    vec_t vecs[8];
    int   nvec;
    sb_t  sb[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;

    doa_tracker #(.LAGNUM(16), .AVG_LOG2(2), .SCREEN_W(640), .PERIOD(100), .TIMEOUT(50)) dut (
        .clk_60MHz(clk), .rst_n(rst_n), .enable(enable), .subsys_start(subsys_start),
        .subsys_done(subsys_done), .lag_diff(lag_diff), .pos_x(pos_x),
        .pos_valid(pos_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: each done pushes the pos_x/pos_valid expected exactly 3 cycles later.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("pos_valid", int'(pos_valid), e.vld);
                chk("pos_x", int'(pos_x), e.pos);
            end else begin
                chk("no_valid", int'(pos_valid), 0);
            end
        end
    end

    task automatic wait_start(output int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!subsys_start && n < 400);
        if (!subsys_start) chk("start_seen", 0, 1);
        s = cyc;
    endtask

    task automatic respond(input int lag, input int exp_pos, input int exp_vld, input int dly);
        repeat (dly) @(negedge clk);
        subsys_done = 1'b1;
        lag_diff    = 6'(lag);
        sb.push_back('{due: cyc + 3, pos: exp_pos, vld: exp_vld});
        @(negedge clk);
        subsys_done = 1'b0;
        lag_diff    = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, prev, e, st, drop_pos, re_pos, re_vld;
        rst_n = 1'b0; enable = 1'b0; subsys_done = 1'b0; lag_diff = '0;
`ifdef DOA_AVG_EN
        nvec = 8;
        vecs[0] = '{4, 339, 0};   vecs[1] = '{4, 359, 0};   vecs[2] = '{4, 379, 0};
        vecs[3] = '{4, 399, 1};   vecs[4] = '{-4, 359, 1};  vecs[5] = '{-16, 259, 1};
        vecs[6] = '{-32, 159, 1}; vecs[7] = '{1, 139, 1};
        drop_pos = 239; re_pos = 359; re_vld = 0;
`else
        nvec = 7;
        vecs[0] = '{-16, 0, 1};   vecs[1] = '{0, 319, 1};   vecs[2] = '{16, 639, 1};
        vecs[3] = '{-32, 0, 1};   vecs[4] = '{31, 639, 1};  vecs[5] = '{8, 479, 1};
        vecs[6] = '{-1, 299, 1};
        drop_pos = 639; re_pos = 479; re_vld = 1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_start", int'(subsys_start), 0);
        chk("rst_pos_x", int'(pos_x), 0);
        chk("rst_valid", int'(pos_valid), 0);
        chk("rst_tmo", int'(timeout_err), 0);
        rst_n = 1'b1;
        st = 0;
        repeat (5) begin @(negedge clk); st += int'(subsys_start); end
        chk("idle_no_start", st, 0);

        enable = 1'b1;
        e = cyc;
        wait_start(s);
        chk("first_start", s, e + 1);
        prev = s;
        for (int i = 0; i < nvec; i++) begin
            if (i > 0) begin
                wait_start(s);
                chk("period", s - prev, 100);
                prev = s;
            end
            respond(vecs[i].lag, vecs[i].pos, vecs[i].vld, 20);
        end

        // watchdog: no done returned
        wait_start(s);
        chk("period_pre_tmo", s - prev, 100);
        prev = s;
        repeat (49) @(negedge clk);
        chk("tmo_before", int'(timeout_err), 0);
        @(negedge clk);
        chk("tmo_rise", int'(timeout_err), 1);

        wait_start(s);
        chk("period_after_tmo", s - prev, 100);
        chk("tmo_sticky", int'(timeout_err), 1);

        // enable drops in WAIT_DONE; pending done still completes
        repeat (5) @(negedge clk);
        enable = 1'b0;
        respond(16, drop_pos, 1, 15);
        repeat (10) @(negedge clk);
        chk("tmo_cleared", int'(timeout_err), 0);
        st = 0;
        repeat (150) begin @(negedge clk); st += int'(subsys_start); end
        chk("no_start_after_drop", st, 0);

        // re-enable: ring restarts empty
        enable = 1'b1;
        e = cyc;
        wait_start(s);
        chk("reenable_start", s, e + 1);
        respond(8, re_pos, re_vld, 20);
        repeat (5) @(negedge clk);

        // reset mid-operation
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pos_x", int'(pos_x), 0);
        chk("midrst_start", int'(subsys_start), 0);
        chk("midrst_tmo", int'(timeout_err), 0);
        rst_n = 1'b1;
        e = cyc;
        wait_start(s);
        chk("post_rst_start", s, e + 1);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/doa_tracker.md
# doa_tracker

Direction-of-arrival tracker sitting directly downstream of the microphone-array sub-system. It periodically pulses that sub-system's start input and captures the signed lag it reports on completion. It smooths successive lags with a moving average and maps the result to a horizontal pixel column for the camera overlay, flagging a watchdog error if the sub-system never completes.

## Interface
Parameters:
- LAGNUM, 16: maximum absolute lag reported upstream; must be a power of two.
- AVG_LOG2, 2: log2 of the moving-average depth (depth = 4).
- SCREEN_W, 640: overlay width in pixels; pos_x spans 0..SCREEN_W-1.
- PERIOD, 600000: cycles between successive subsys_start pulses (10 ms at 60 MHz).
- TIMEOUT, 6000000: maximum cycles to wait for subsys_done.

Ports:
- clk_60MHz, in, 1: the only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: level; tracking runs while high.
- subsys_start, out, 1: one-cycle start pulse to the upstream sub-system.
- subsys_done, in, 1: one-cycle completion pulse from upstream.
- lag_diff, in, 6 signed: upstream lag, valid in the subsys_done cycle.
- pos_x, out, 11: mapped pixel column.
- pos_valid, out, 1: one-cycle pulse when pos_x updates.
- timeout_err, out, 1: sticky watchdog flag.

## Operation
- FSM states and transitions:
  - IDLE: when enable=1, go to START.
  - START: assert subsys_start for this one cycle; load the period counter with PERIOD-1 and the watchdog with TIMEOUT-1; go to WAIT_DONE.
  - WAIT_DONE:
    - On subsys_done=1, capture lag_diff and go to FILTER.
    - Otherwise, when the watchdog reaches 0, set timeout_err and go to WAIT_PERIOD without updating the filter.
  - FILTER: write the lag into the ring buffer, update the running sum and fill count; go to MAP.
  - MAP: compute the pixel column and register pos_x; pulse pos_valid; go to WAIT_PERIOD.
  - WAIT_PERIOD: go to START when the period counter is 0. The counter decrements in every state after START.
    - If a measurement overran PERIOD, START follows MAP immediately.
- Clamping: the captured lag is clamped to [-LAGNUM, +LAGNUM] (6-bit signed). Out-of-range codes, e.g. -32, saturate.
- Averaging: the ring holds 2^AVG_LOG2 lags.
  - Running sum is signed, 6+AVG_LOG2 bits; each update adds the new lag and subtracts the evicted one.
  - Average = sum >>> AVG_LOG2 (arithmetic shift, rounds toward minus infinity).
  - pos_valid is suppressed until the ring has been filled once; pos_x still updates during fill.
- Mapping: pos_x = ((avg + LAGNUM) * (SCREEN_W-1)) >> log2(2*LAGNUM), unsigned, full-width product, floored.
  - With defaults, lag -16 gives 0, lag 0 gives 319, lag +16 gives 639.
- enable falling:
  - In WAIT_PERIOD or START, return to IDLE at once.
  - In WAIT_DONE, FILTER or MAP, finish the current measurement (done or timeout), then return to IDLE. Upstream cannot be aborted.
  - On entry to IDLE: clear the ring, sum, fill count and timeout_err; pos_x holds its value.
- subsys_done outside WAIT_DONE is ignored. A simultaneous done and watchdog expiry is treated as done.

## Timing
- Reset values: subsys_start=0, pos_x=0, pos_valid=0, timeout_err=0, state IDLE; all counters and the ring are 0.
- Reset mid-operation returns to IDLE immediately; no pulse is emitted in the reset-release cycle.
- subsys_start rises 1 cycle after enable is sampled high in IDLE.
- pos_valid is high exactly 3 cycles after the cycle in which subsys_done was sampled high.
- Steady-state start-to-start spacing is max(PERIOD, measurement time + 3) cycles.
- The lag_diff to pos_x pipeline is fully registered; there is no combinational path from input to output.

## Configuration
- DOA_AVG_EN defined: moving average as above; pos_valid is gated by ring fill.
- DOA_AVG_EN undefined:
  - No ring and no sum; avg equals the clamped lag.
  - FILTER is kept as a pass-through cycle, so latency is unchanged (3 cycles).
  - pos_valid fires on the first measurement.

## Test plan
- Reset, then enable=1 with PERIOD=100 and done returned 20 cycles after each start -> subsys_start pulses every 100 cycles; pos_valid appears 3 cycles after each done.
- Undefined DOA_AVG_EN, lags -16, 0, +16 -> pos_x = 0, 319, 639.
- DOA_AVG_EN defined, lags 4, 4, 4, 4, then -4 -> no pos_valid on the first 3; then pos_x for avg 4 = 399; then for avg 2 = 359.
- Lag -32 injected -> clamped to -16; with DOA_AVG_EN undefined, pos_x = 0.
- TIMEOUT=50, subsys_done never asserted -> timeout_err rises 50 cycles after start; the next start follows on schedule; pos_valid stays 0.
- enable dropped while in WAIT_DONE -> the pending done still yields pos_valid; then IDLE with timeout_err cleared; no further subsys_start.
